// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM encoding,
// RVC detection and the layout of one instruction-queue entry.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    DROP    = 2'd3
  } fetch_state_t;

  // Any 16-bit parcel whose low two bits are not 2'b11 starts a compressed instruction.
  localparam logic [1:0] RVC_MASK = 2'b11;

  localparam int ENTRY_W   = 64 + 32 + 1;
  localparam int RVC_OFS   = 0;
  localparam int INSTR_OFS = 1;
  localparam int PC_OFS    = 33;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        is_rvc;
  } fetch_entry_t;

  function automatic logic is_compressed(input logic [15:0] half);
    return (half[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage

// File: rtl/gen_fifo.sv
// Generic synchronous FIFO, 2^AW entries of DW bits, with a flush that empties
// it and overrides any push/pop in the same cycle.
module gen_fifo #(
  parameter int DW = 97,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int DP = 1 << AW;

  logic [DW-1:0] mem [DP];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // NOTE: only sequential state uses non-blocking assignments, so every
  // always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK) begin
    if (!RSTn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so clearing data would only cost area.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one or two word reads per accepted PC, RVC/32-bit
// realignment (including word-straddling instructions), and a decode queue.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          AW       = 2,
  parameter logic [63:0] RST_ADDR = 64'h8000_0000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush,
  input  logic        pc_valid,
  input  logic [63:0] pc_in,
  output logic        pc_ready,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        is_rvc
);

  if (RST_ADDR[0] != 1'b0) begin : g_rst_addr_check
    $error("RST_ADDR must be 2-byte aligned");
  end

  fetch_state_t        state;
  logic [63:0]         pc_q;
  logic [15:0]         lo_half;
  logic [15:0]         sel_half;
  logic                rvc_hit;
  logic                straddle;
  logic                push;
  fetch_entry_t        push_entry;
  logic [ENTRY_W-1:0]  q_dout;
  logic                q_empty;
  logic                q_full;

  assign pc_ready = (state == IDLE) & ~q_full & ~flush;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_half   = pc_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    rvc_hit    = is_compressed(sel_half);
    straddle   = pc_q[1] & ~rvc_hit;
    push       = 1'b0;
    push_entry = '{pc: pc_q, instr: mem_rsp_data, is_rvc: 1'b0};
    if (mem_rsp_valid && !flush) begin
      unique case (state)
        WAIT_LO: begin
          if (rvc_hit) begin
            push              = 1'b1;
            push_entry.instr  = {16'b0, sel_half};
            push_entry.is_rvc = 1'b1;
          end else if (!pc_q[1]) begin
            push = 1'b1;
          end
        end
        WAIT_HI: begin
          push             = 1'b1;
          push_entry.instr = {mem_rsp_data[15:0], lo_half};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state         <= IDLE;
      pc_q          <= '0;
      lo_half       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      mem_req_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pc_valid && pc_ready) begin
            pc_q          <= pc_in;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {pc_in[63:2], 2'b00};
            state         <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (flush) begin
            // A response arriving with the flush is simply dropped; otherwise it is still owed.
            state <= mem_rsp_valid ? IDLE : DROP;
          end else if (mem_rsp_valid) begin
            if (straddle) begin
              lo_half       <= mem_rsp_data[31:16];
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + 64'd4;
              state         <= WAIT_HI;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT_HI: begin
          if (flush)              state <= mem_rsp_valid ? IDLE : DROP;
          else if (mem_rsp_valid) state <= IDLE;
        end
        DROP: begin
          if (mem_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gen_fifo #(
    .DW(ENTRY_W),
    .AW(AW)
  ) u_queue (
    .CLK  (CLK),
    .RSTn (RSTn),
    .flush(flush),
    .push (push),
    .din  (push_entry),
    .pop  (instr_ready),
    .dout (q_dout),
    .empty(q_empty),
    .full (q_full)
  );

  assign instr_valid = ~q_empty;
  assign instr       = q_dout[INSTR_OFS +: 32];
  assign instr_pc    = q_dout[PC_OFS +: 64];
  assign is_rvc      = q_dout[RVC_OFS];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a scripted memory responder
// of programmable latency.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        flush;
  logic        pc_valid;
  logic [63:0] pc_in;
  logic        pc_ready;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        is_rvc;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rsp_q[$];
  logic [63:0] req_addr_q[$];
  int          req_cnt = 0;
  int          lat = 1;

  always #5 CLK = ~CLK;

  instr_fetch #(.AW(2)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .flush        (flush),
    .pc_valid     (pc_valid),
    .pc_in        (pc_in),
    .pc_ready     (pc_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .is_rvc       (is_rvc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Memory model: logs each request, answers it `lat` cycles later from rsp_q.
  initial begin
    bit pend;
    int cd;
    pend = 0;
    cd = 0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge CLK);
      #1;
      mem_rsp_valid = 1'b0;
      if (pend) begin
        if (cd <= 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
          pend = 0;
        end else begin
          cd--;
        end
      end
      @(negedge CLK);
      if (mem_req_valid) begin
        req_addr_q.push_back(mem_req_addr);
        req_cnt++;
        pend = 1;
        cd = lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts at posedge+1 in IDLE with an empty queue and instr_ready=1; ends at posedge+1.
  task automatic do_fetch(input string tag, input logic [63:0] pc,
                          input logic [31:0] w0, input logic [31:0] w1, input int nrsp,
                          input int exp_lat, input logic [31:0] exp_instr, input logic exp_rvc,
                          input logic [63:0] a0, input logic [63:0] a1);
    int n;
    req_addr_q.delete();
    rsp_q.push_back(w0);
    if (nrsp == 2) rsp_q.push_back(w1);
    pc_valid = 1'b1;
    pc_in    = pc;
    settle();
    check({tag, "_pc_ready"}, pc_ready, 1'b1);
    tick();
    pc_valid = 1'b0;
    n = 1;
    settle();
    while (!instr_valid && n < 20) begin
      tick();
      n++;
      settle();
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_instr"}, instr, exp_instr);
    check({tag, "_is_rvc"}, is_rvc, exp_rvc);
    check({tag, "_instr_pc"}, instr_pc, pc);
    check({tag, "_nreq"}, req_addr_q.size(), nrsp);
    if (req_addr_q.size() > 0) check({tag, "_addr0"}, req_addr_q[0], a0);
    if (nrsp == 2 && req_addr_q.size() > 1) check({tag, "_addr1"}, req_addr_q[1], a1);
    tick();
  endtask

  logic [63:0] bp_pc  [5];
  logic [31:0] bp_data[5];

  initial begin
    int n;
    int base;
    RSTn        = 1'b0;
    flush       = 1'b0;
    pc_valid    = 1'b0;
    pc_in       = '0;
    instr_ready = 1'b1;
    repeat (3) tick();
    settle();
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    tick();
    RSTn = 1'b1;
    settle();
    check("post_rst_pc_ready", pc_ready, 1'b1);
    check("post_rst_req_addr", mem_req_addr, 64'h0);
    tick();

    // Aligned 32-bit, RVC low half, RVC high half, straddle, straddle across 64-bit wrap.
    do_fetch("aligned32", 64'h8000_0000, 32'h0000_0093, 32'h0, 1, 3, 32'h0000_0093, 1'b0,
             64'h8000_0000, 64'h0);
    do_fetch("rvc_lo", 64'h8000_0004, 32'h1234_4501, 32'h0, 1, 3, 32'h0000_4501, 1'b1,
             64'h8000_0004, 64'h0);
    do_fetch("rvc_hi", 64'h8000_0006, 32'h8082_0000, 32'h0, 1, 3, 32'h0000_8082, 1'b1,
             64'h8000_0004, 64'h0);
    do_fetch("straddle", 64'h8000_0002, 32'h0513_1234, 32'hFFFF_0000, 2, 5, 32'h0000_0513, 1'b0,
             64'h8000_0000, 64'h8000_0004);
    do_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 32'h0003_0000, 32'h0000_1111, 2, 5, 32'h1111_0003,
             1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);

    // Flush in the same cycle as the response: response dropped, back to IDLE.
    rsp_q.push_back(32'h0000_0093);
    pc_valid = 1'b1;
    pc_in    = 64'h8000_0010;
    settle();
    tick();
    pc_valid = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    check("flush_rsp_pc_ready", pc_ready, 1'b0);
    tick();
    flush = 1'b0;
    settle();
    check("flush_rsp_instr_valid", instr_valid, 1'b0);
    check("flush_rsp_pc_ready_after", pc_ready, 1'b1);
    tick();

    // Flush in WAIT_HI (held for two cycles) before the second response arrives.
    lat = 3;
    rsp_q.push_back(32'h0513_1234);
    rsp_q.push_back(32'hFFFF_0000);
    base = req_cnt;
    pc_valid = 1'b1;
    pc_in    = 64'h8000_0002;
    settle();
    tick();
    pc_valid = 1'b0;
    n = 0;
    settle();
    while (req_cnt < base + 2 && n < 20) begin
      tick();
      n++;
      settle();
    end
    check("drop_second_req_seen", req_cnt, base + 2);
    tick();
    flush = 1'b1;
    settle();
    check("drop_flush_pc_ready", pc_ready, 1'b0);
    tick();
    settle();
    tick();
    flush = 1'b0;
    settle();
    check("drop_state_pc_ready", pc_ready, 1'b0);
    check("drop_instr_valid", instr_valid, 1'b0);
    n = 0;
    while (!mem_rsp_valid && n < 20) begin
      tick();
      n++;
      settle();
    end
    check("drop_rsp_seen", mem_rsp_valid, 1'b1);
    tick();
    settle();
    check("drop_done_pc_ready", pc_ready, 1'b1);
    check("drop_done_instr_valid", instr_valid, 1'b0);
    tick();
    lat = 1;
    do_fetch("after_drop", 64'h8000_0020, 32'h0000_0013, 32'h0, 1, 3, 32'h0000_0013, 1'b0,
             64'h8000_0020, 64'h0);

    // Backpressure: fill all four entries, then pop one and overlap push with pop.
    for (int i = 0; i < 5; i++) begin
      bp_pc[i]   = 64'h8000_0100 + 64'(i * 4);
      bp_data[i] = 32'h0000_0093 + (32'(i) << 20);
    end
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back(bp_data[i]);
      pc_valid = 1'b1;
      pc_in    = bp_pc[i];
      settle();
      check($sformatf("bp_accept%0d", i), pc_ready, 1'b1);
      tick();
      pc_valid = 1'b0;
      tick();
      tick();
    end
    rsp_q.push_back(bp_data[4]);
    pc_valid = 1'b1;
    pc_in    = bp_pc[4];
    base     = req_cnt;
    settle();
    check("bp_full_pc_ready", pc_ready, 1'b0);
    repeat (3) begin
      tick();
      settle();
    end
    check("bp_full_no_req", req_cnt, base);
    check("bp_full_head", instr, bp_data[0]);
    check("bp_full_still_blocked", pc_ready, 1'b0);
    tick();
    instr_ready = 1'b1;
    settle();
    check("bp_pop_cycle_pc_ready", pc_ready, 1'b0);
    tick();
    instr_ready = 1'b0;
    settle();
    check("bp_after_pop_pc_ready", pc_ready, 1'b1);
    check("bp_after_pop_head", instr, bp_data[1]);
    tick();
    pc_valid = 1'b0;
    settle();
    check("bp_refill_req", mem_req_valid, 1'b1);
    tick();
    instr_ready = 1'b1;
    settle();
    tick();
    instr_ready = 1'b0;
    settle();
    check("bp_push_pop_pc_ready", pc_ready, 1'b1);
    check("bp_push_pop_head", instr, bp_data[2]);
    tick();
    instr_ready = 1'b1;
    for (int k = 2; k < 5; k++) begin
      settle();
      check($sformatf("bp_drain_valid%0d", k), instr_valid, 1'b1);
      check($sformatf("bp_drain_instr%0d", k), instr, bp_data[k]);
      check($sformatf("bp_drain_pc%0d", k), instr_pc, bp_pc[k]);
      tick();
    end
    settle();
    check("bp_drained_empty", instr_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
